// File: rtl/rv32i_io_responder.sv
// rv32i_io_responder
// Memory-mapped IO responder for the data-side IO port of the rv32i pipeline.
// Read data is registered (one-cycle latency, read-before-write), in step with
// the synchronous data RAM. Writes are word-addressed with per-byte enables.
//
// Register map (byte offset from BASE_ADDR):
//   0x00 LED   RW   led_out value, bits above LED_WIDTH read 0
//   0x04 SW    RO   sw_in after a 2-flop synchronizer, zero-extended
//   0x08 CYCLE RO   free-running cycle counter
//   0x0C TCNT  RW   timer count          (IO_TIMER_EN only)
//   0x10 TCMP  RW   timer compare value  (IO_TIMER_EN only)
//   0x14 TCTRL      bit0 EN, bit1 AUTO, bit2 FLAG (W1C), bit3 IE (IO_TIMER_EN only)
//   0x18 ID    RO   32'h5256_3332
//
// Build option: define IO_TIMER_EN to include the compare timer. Without it the
// timer offsets read 0, ignore writes, and irq_out is tied low.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   io_we     write enable from memory stage
//   io_addr   word address [31:2]
//   io_be     byte enables, bit n covers io_wdata[8n+7:8n]
//   io_wdata  lane-aligned write data
//   io_rdata  registered read data
//   sw_in     asynchronous switch inputs
//   led_out   LED register
//   irq_out   timer interrupt level (FLAG & IE)
module rv32i_io_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int          LED_WIDTH = 8,
    parameter int          SW_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_we,
    input  logic [31:2]          io_addr,
    input  logic [3:0]           io_be,
    input  logic [31:0]          io_wdata,
    output logic [31:0]          io_rdata,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq_out
);

    localparam logic [5:0]  OFF_LED   = 6'd0;
    localparam logic [5:0]  OFF_SW    = 6'd1;
    localparam logic [5:0]  OFF_CYCLE = 6'd2;
    localparam logic [5:0]  OFF_TCNT  = 6'd3;
    localparam logic [5:0]  OFF_TCMP  = 6'd4;
    localparam logic [5:0]  OFF_TCTRL = 6'd5;
    localparam logic [5:0]  OFF_ID    = 6'd6;
    localparam logic [31:0] ID_WORD   = 32'h5256_3332;

    logic       hit;
    logic [5:0] word_sel;
    logic       wr_en;

    assign hit      = (io_addr[31:8] == BASE_ADDR[31:8]);
    assign word_sel = io_addr[7:2];
    assign wr_en    = io_we && hit;

    // Depending on LED_WIDTH and the timer option, some write-data / enable
    // bits feed nothing; fold them here so they are visibly intentional.
    logic unused_wr_bits;
    assign unused_wr_bits = ^{io_wdata, io_be};

    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]          cycle_q, cycle_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          tcnt_rd, tcmp_rd, tctrl_rd;

    // Byte-merged LED write value, one bit at a time so only the implemented
    // LED bits are built.
    genvar gi;
    generate
        for (gi = 0; gi < LED_WIDTH; gi++) begin : g_led_merge
            assign led_d[gi] = io_be[gi / 8] ? io_wdata[gi] : led_q[gi];
        end
    endgenerate

    assign cycle_d = cycle_q + 32'd1;

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (word_sel)
                OFF_LED:   rdata_d = 32'(led_q);
                OFF_SW:    rdata_d = 32'(sw_sync_q);
                OFF_CYCLE: rdata_d = cycle_q;
                OFF_TCNT:  rdata_d = tcnt_rd;
                OFF_TCMP:  rdata_d = tcmp_rd;
                OFF_TCTRL: rdata_d = tctrl_rd;
                OFF_ID:    rdata_d = ID_WORD;
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (wr_en && (word_sel == OFF_LED)) begin
                led_q <= led_d;
            end
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_d;
            // Sampled from current register state, so a same-cycle write is
            // only visible on the following read.
            rdata_q   <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;
    assign led_out  = led_q;

`ifdef IO_TIMER_EN
    logic [31:0] be_mask;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_mask
            assign be_mask[8*gi +: 8] = {8{io_be[gi]}};
        end
    endgenerate

    logic [31:0] tcnt_q, tcmp_q, tcnt_d, tcmp_d;
    logic        en_q, auto_q, flag_q, ie_q;
    logic        match;

    assign tcnt_d = (tcnt_q & ~be_mask) | (io_wdata & be_mask);
    assign tcmp_d = (tcmp_q & ~be_mask) | (io_wdata & be_mask);
    assign match  = en_q && (tcnt_q == tcmp_q);

    // Later assignments win: hardware count/reload, then software writes,
    // then the hardware FLAG set (so a match beats a same-cycle W1C).
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            tcmp_q <= '0;
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            flag_q <= 1'b0;
            ie_q   <= 1'b0;
        end else begin
            if (match) begin
                // Auto mode reloads and keeps running; one-shot holds and stops.
                if (auto_q) begin
                    tcnt_q <= '0;
                end
                en_q <= auto_q;
            end else if (en_q) begin
                tcnt_q <= tcnt_q + 32'd1;
            end
            if (wr_en && (word_sel == OFF_TCNT)) begin
                tcnt_q <= tcnt_d;
            end
            if (wr_en && (word_sel == OFF_TCMP)) begin
                tcmp_q <= tcmp_d;
            end
            if (wr_en && (word_sel == OFF_TCTRL) && io_be[0]) begin
                en_q   <= io_wdata[0];
                auto_q <= io_wdata[1];
                ie_q   <= io_wdata[3];
                if (io_wdata[2]) begin
                    flag_q <= 1'b0;
                end
            end
            if (match) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign tcnt_rd  = tcnt_q;
    assign tcmp_rd  = tcmp_q;
    assign tctrl_rd = {28'd0, ie_q, flag_q, auto_q, en_q};
    assign irq_out  = flag_q & ie_q;
`else
    assign tcnt_rd  = '0;
    assign tcmp_rd  = '0;
    assign tctrl_rd = '0;
    assign irq_out  = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_io_responder.sv
module tb_rv32i_io_responder;

    localparam logic [31:0] BASE     = 32'h0000_FF00;
    localparam int          LW       = 8;
    localparam int          SWW      = 8;
    localparam logic [31:0] LED_MASK = (LW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LW) - 32'd1);
`ifdef IO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            io_we = 1'b0;
    logic [31:2]     io_addr = '0;
    logic [3:0]      io_be = '0;
    logic [31:0]     io_wdata = '0;
    logic [31:0]     io_rdata;
    logic [SWW-1:0]  sw_in = '0;
    logic [LW-1:0]   led_out;
    logic            irq_out;

    always #5 clk = ~clk;

    rv32i_io_responder #(
        .BASE_ADDR(BASE),
        .LED_WIDTH(LW),
        .SW_WIDTH (SWW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_we   (io_we),
        .io_addr (io_addr),
        .io_be   (io_be),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .sw_in   (sw_in),
        .led_out (led_out),
        .irq_out (irq_out)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] led;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model state: register contents as software sees them.
    logic [31:0] m_led, m_cycle, m_tcnt, m_tcmp;
    logic [7:0]  m_sw1, m_sw2;
    bit          m_en, m_auto, m_flag, m_ie;
    logic [7:0]  sw_cur = 8'h00;

    function automatic logic [29:0] wa(logic [31:0] byte_off);
        logic [31:0] x;
        x = BASE + byte_off;
        return x[31:2];
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(logic [29:0] a);
        if (a[29:6] != BASE[31:8]) return 32'd0;
        case (int'(a[5:0]))
            0: return m_led;
            1: return {24'd0, m_sw2};
            2: return m_cycle;
            3: return TIMER ? m_tcnt : 32'd0;
            4: return TIMER ? m_tcmp : 32'd0;
            5: return TIMER ? {28'd0, m_ie, m_flag, m_auto, m_en} : 32'd0;
            6: return 32'h5256_3332;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(bit rst, bit we, logic [29:0] a, logic [3:0] be,
                          logic [31:0] wd, logic [7:0] sw);
        bit          wr;
        int          off;
        bit          fire;
        logic [31:0] cnt_n;
        bit          en_n;
        if (rst) begin
            m_led = 0; m_cycle = 0; m_tcnt = 0; m_tcmp = 0;
            m_sw1 = 0; m_sw2 = 0;
            m_en = 0; m_auto = 0; m_flag = 0; m_ie = 0;
            return;
        end
        wr  = we && (a[29:6] == BASE[31:8]);
        off = int'(a[5:0]);
        if (wr && off == 0) m_led = merge(m_led, wd, be) & LED_MASK;
        m_sw2   = m_sw1;
        m_sw1   = sw;
        m_cycle = m_cycle + 1;
        if (TIMER) begin
            fire  = m_en && (m_tcnt == m_tcmp);
            cnt_n = m_tcnt;
            en_n  = m_en;
            if (fire) begin
                en_n = m_auto;
                if (m_auto) cnt_n = 0;
            end else if (m_en) begin
                cnt_n = m_tcnt + 1;
            end
            if (wr && off == 3) cnt_n = merge(m_tcnt, wd, be);
            if (wr && off == 4) m_tcmp = merge(m_tcmp, wd, be);
            if (wr && off == 5 && be[0]) begin
                en_n   = wd[0];
                m_auto = wd[1];
                m_ie   = wd[3];
                if (wd[2]) m_flag = 0;
            end
            if (fire) m_flag = 1;
            m_tcnt = cnt_n;
            m_en   = en_n;
        end
    endtask

    // Present one cycle of stimulus and queue what the DUT must show after the edge.
    task automatic drive(bit rst, bit we, logic [29:0] a, logic [3:0] be, logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        io_we    = we;
        io_addr  = a;
        io_be    = be;
        io_wdata = wd;
        sw_in    = sw_cur;
        e.rdata  = rst ? 32'd0 : m_read(a);
        m_step(rst, we, a, be, wd, sw_cur);
        e.led    = m_led;
        e.irq    = TIMER & m_flag & m_ie;
        exp_q.push_back(e);
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: rdata=%h led=%h irq=%b", n_txn, io_rdata, led_out, irq_out);
            n_vec++;
            if (io_rdata !== mon_e.rdata) begin
                n_bad++;
                $display("FAIL rdata txn %0d: got %h expected %h", n_txn, io_rdata, mon_e.rdata);
            end
            n_vec++;
            if (32'(led_out) !== mon_e.led) begin
                n_bad++;
                $display("FAIL led txn %0d: got %h expected %h", n_txn, led_out, mon_e.led);
            end
            n_vec++;
            if (irq_out !== mon_e.irq) begin
                n_bad++;
                $display("FAIL irq txn %0d: got %b expected %b", n_txn, irq_out, mon_e.irq);
            end
        end
    end

    initial begin
        int          r;
        logic [31:0] off;
        logic [29:0] a;
        bit          we;
        logic [31:0] wd;

        // Reset, with a write during reset that must be dropped.
        drive(1, 0, wa(0), 4'h0, 0);
        drive(1, 1, wa(0), 4'hF, 32'hFF);
        for (int k = 0; k < 7; k++) drive(0, 0, wa(4 * k), 4'h0, 0);

        // LED byte-enable writes.
        drive(0, 1, wa(0), 4'b0001, 32'h0000_00A5);
        drive(0, 1, wa(0), 4'b0010, 32'hFFFF_FF3C);
        drive(0, 0, wa(0), 4'h0, 0);
        drive(0, 1, wa(0), 4'b1111, 32'h1234_5677);
        drive(0, 0, wa(0), 4'h0, 0);

        // Switch synchronizer latency.
        drive(0, 0, wa(4), 4'h0, 0);
        sw_cur = 8'h5A;
        for (int k = 0; k < 5; k++) drive(0, 0, wa(4), 4'h0, 0);

        // Auto-reload timer with interrupt, then W1C attempts.
        drive(0, 1, wa(32'h10), 4'hF, 5);
        drive(0, 1, wa(32'h14), 4'h1, 32'hB);
        for (int k = 0; k < 14; k++) drive(0, 0, wa(32'h0C), 4'h0, 0);
        for (int k = 0; k < 8; k++) drive(0, 1, wa(32'h14), 4'h1, 32'hF);
        for (int k = 0; k < 3; k++) drive(0, 0, wa(32'h14), 4'h0, 0);

        // One-shot timer stops at compare value and clears EN.
        drive(0, 1, wa(32'h14), 4'h1, 0);
        drive(0, 1, wa(32'h0C), 4'hF, 0);
        drive(0, 1, wa(32'h10), 4'hF, 3);
        drive(0, 1, wa(32'h14), 4'h1, 32'h9);
        for (int k = 0; k < 6; k++) drive(0, 0, wa(32'h0C), 4'h0, 0);
        drive(0, 0, wa(32'h14), 4'h0, 0);

        // Software TCNT write during counting overrides the increment.
        drive(0, 1, wa(32'h10), 4'hF, 32'h100);
        drive(0, 1, wa(32'h14), 4'h1, 32'h1);
        drive(0, 0, wa(32'h0C), 4'h0, 0);
        drive(0, 1, wa(32'h0C), 4'hF, 32'h10);
        drive(0, 0, wa(32'h0C), 4'h0, 0);
        drive(0, 0, wa(32'h0C), 4'h0, 0);

        // Misses, unmapped offset and (in the timer-less build) dead offsets.
        drive(0, 1, wa(32'h100), 4'hF, 32'hDEAD_BEEF);
        drive(0, 1, wa(32'h1C), 4'hF, 32'hCAFE_F00D);
        drive(0, 1, wa(32'h10), 4'hF, 32'h1234);
        drive(0, 0, wa(32'h10), 4'h0, 0);
        drive(0, 0, wa(32'h1C), 4'h0, 0);
        drive(0, 0, wa(32'h100), 4'h0, 0);
        drive(0, 0, wa(0), 4'h0, 0);

        // Mid-operation reset, then TCMP=0/TCNT=0 fires as soon as EN is set.
        drive(1, 1, wa(0), 4'hF, 32'hFF);
        for (int k = 0; k < 7; k++) drive(0, 0, wa(4 * k), 4'h0, 0);
        drive(0, 1, wa(32'h14), 4'h1, 32'h9);
        drive(0, 0, wa(32'h14), 4'h0, 0);
        drive(0, 0, wa(32'h14), 4'h0, 0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            r   = int'($urandom_range(0, 99));
            off = 32'($urandom_range(0, 7)) * 4;
            a   = (r < 5) ? wa(32'h100 + off) : wa(off);
            we  = ($urandom_range(0, 2) == 0);
            wd  = $urandom;
            if (off == 32'h0C || off == 32'h10) wd = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 19) == 0) sw_cur = 8'($urandom);
            drive($urandom_range(0, 299) == 0, we, a, 4'($urandom), wd);
        end
        drive(0, 0, wa(0), 4'h0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
